led_line_scheduler: RTL and testbench

//  Round-robin arbiter sharing one SK6805 bit-serializer among N_CH LED lines.
//  - Each line requests a refresh with a 24-bit colour.
//  - The winner's colour is latched and the serializer is started.
//  - The serializer output is routed to that line via line_sel.
//  - A reset-low gap is enforced before the next frame.

---
 rtl/led_line_scheduler_if.sv | 28 ++
 rtl/led_line_scheduler.sv | 126 ++++++++++++
 tb/tb_led_line_scheduler.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/led_line_scheduler_if.sv
// Bundle between LED-line requesters, the shared
// serializer and the line scheduler.
interface led_line_scheduler_if #(
  parameter int N_CH = 6
);
  logic [N_CH-1:0]    req;
  logic [N_CH-1:0]    en;
  logic [24*N_CH-1:0] colour;
  logic [N_CH-1:0]    ack;
  logic               drv_start;
  logic [23:0]        drv_grb;
  logic               drv_done;
  logic [N_CH-1:0]    line_sel;
  logic               busy;
  logic               err_timeout;

  modport master (
    input  req, en, colour, drv_done,
    output ack, drv_start, drv_grb,
    output line_sel, busy, err_timeout
  );

  modport slave (
    output req, en, colour, drv_done,
    input  ack, drv_start, drv_grb,
    input  line_sel, busy, err_timeout
  );
endinterface

// File: rtl/led_line_scheduler.sv
// Round-robin scheduler sharing one SK6805
// serializer among N_CH LED lines.
module led_line_scheduler #(
  parameter int N_CH           = 6,
  parameter int RESET_CYCLES   = 800,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic clk_10MHz,
  input logic Rst,
  led_line_scheduler_if.master bus
);
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CMAX = (RESET_CYCLES > TIMEOUT_CYCLES)
                      ? RESET_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX);
  localparam logic [CW-1:0] GAP_END = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TO_END  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, START, SEND, GAP
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [23:0]     grb_q, grb_d;
  logic [N_CH-1:0] ack_q, ack_d;
  logic            err_q, err_d;

  logic [N_CH-1:0] elig;
  logic [N_CH-1:0] sel_oh;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   win;
  logic            found;
  logic [23:0]     wcol;

  assign elig   = bus.req & bus.en;
  assign sel_oh = {{(N_CH-1){1'b0}}, 1'b1} << rr_q;

  // First eligible line strictly after the last winner, wrapping.
  always_comb begin
    found = 1'b0;
    win   = rr_q;
    idx   = rr_q;
    for (int k = 0; k < N_CH; k++) begin
      idx = (idx == IW'(N_CH - 1)) ? '0 : idx + 1'b1;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    wcol = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (win == IW'(i)) wcol = bus.colour[24*i +: 24];
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    grb_d   = grb_q;
    ack_d   = '0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          rr_d    = win;
          grb_d   = {wcol[15:8], wcol[23:16], wcol[7:0]};
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (bus.drv_done) begin
          ack_d   = sel_oh;
          cnt_d   = '0;
          state_d = GAP;
        end else if (cnt_q >= TO_END) begin
          ack_d   = sel_oh;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q >= GAP_END) state_d = IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_10MHz) begin
    if (Rst) begin
      state_q <= IDLE;
      rr_q    <= IW'(N_CH - 1);
      cnt_q   <= '0;
      grb_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      grb_q   <= grb_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign bus.drv_start   = (state_q == START);
  assign bus.busy        = (state_q != IDLE);
  assign bus.line_sel    = bus.busy ? sel_oh : '0;
  assign bus.drv_grb     = grb_q;
  assign bus.ack         = ack_q;
  assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_led_line_scheduler.sv
// Bench for led_line_scheduler: directed steps plus
// randomized frames against a transaction-level model.
module tb_led_line_scheduler;
  localparam int N  = 6;
  localparam int RC = 800;
  localparam int TO = 4096;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   last;

  led_line_scheduler_if #(.N_CH(N)) bus ();

  led_line_scheduler #(
    .N_CH(N),
    .RESET_CYCLES(RC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_10MHz(clk),
    .Rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] swz(input logic [23:0] c);
    return {c[15:8], c[23:16], c[7:0]};
  endfunction

  // Next eligible line after the last winner, wrapping.
  function automatic int predict(input logic [N-1:0] e);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (e[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"},   32'(bus.ack), 32'd0);
    chk({tag, "_start"}, 32'(bus.drv_start), 32'd0);
    chk({tag, "_grb"},   32'(bus.drv_grb), 32'd0);
    chk({tag, "_sel"},   32'(bus.line_sel), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_err"},   32'(bus.err_timeout), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_zero("rst");
    rst  = 1'b0;
    last = N - 1;
  endtask

  // Called at a negedge with the DUT idle and inputs set.
  task automatic frame(input int dly, input bit to,
                       input bit drop_req, input bit drop_en,
                       input bit chg);
    int w;
    logic [23:0] c;
    logic [N-1:0] oh;
    w = predict(bus.req & bus.en);
    if (w < 0) w = 0;
    c  = bus.colour[24*w +: 24];
    oh = N'(1) << w;
    last = w;
    @(negedge clk);
    chk("start", 32'(bus.drv_start), 32'd1);
    chk("sel_start", 32'(bus.line_sel), 32'(oh));
    chk("grb_start", 32'(bus.drv_grb), 32'(swz(c)));
    chk("busy_start", 32'(bus.busy), 32'd1);
    if (chg) begin
      for (int i = 0; i < N; i++)
        bus.colour[24*i +: 24] = 24'($urandom);
    end
    if (drop_en) bus.en[w] = 1'b0;
    @(negedge clk);
    chk("start_pulse", 32'(bus.drv_start), 32'd0);
    if (!to) begin
      repeat (dly - 1) @(negedge clk);
      bus.drv_done = 1'b1;
      @(negedge clk);
      bus.drv_done = 1'b0;
    end else begin
      repeat (TO - 1) @(negedge clk);
      chk("to_early", 32'(bus.ack), 32'd0);
      @(negedge clk);
    end
    chk("ack", 32'(bus.ack), 32'(oh));
    chk("err", 32'(bus.err_timeout), 32'(to));
    chk("grb_hold", 32'(bus.drv_grb), 32'(swz(c)));
    chk("sel_ack", 32'(bus.line_sel), 32'(oh));
    if (drop_req) bus.req[w] = 1'b0;
    @(negedge clk);
    chk("ack_pulse", 32'(bus.ack), 32'd0);
    chk("err_pulse", 32'(bus.err_timeout), 32'd0);
    bus.drv_done = 1'b1;
    @(negedge clk);
    bus.drv_done = 1'b0;
    repeat (RC - 3) @(negedge clk);
    chk("gap_busy", 32'(bus.busy), 32'd1);
    chk("gap_sel", 32'(bus.line_sel), 32'(oh));
    chk("gap_ack", 32'(bus.ack), 32'd0);
    @(negedge clk);
    chk("end_busy", 32'(bus.busy), 32'd0);
    chk("end_sel", 32'(bus.line_sel), 32'd0);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    last         = N - 1;
    rst          = 1'b1;
    bus.req      = '0;
    bus.en       = '0;
    bus.colour   = '0;
    bus.drv_done = 1'b0;
    @(negedge clk);
    do_reset();

    // Single frame, 240-cycle serializer
    bus.en = '1;
    bus.colour[23:0] = 24'hFF0000;
    bus.req = 6'b000001;
    frame(240, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.req = '0;

    // Stray done while idle
    bus.drv_done = 1'b1;
    @(negedge clk);
    bus.drv_done = 1'b0;
    chk("stray_busy", 32'(bus.busy), 32'd0);
    chk("stray_ack", 32'(bus.ack), 32'd0);
    @(negedge clk);
    chk("stray_start", 32'(bus.drv_start), 32'd0);

    // Held requests rotate fairly
    do_reset();
    bus.en = '1;
    for (int i = 0; i < N; i++)
      bus.colour[24*i +: 24] = 24'(i);
    bus.req = 6'b100101;
    for (int n = 0; n < 6; n++)
      frame(int'($urandom_range(1, 60)), 1'b0, 1'b0,
            1'b0, 1'b0);
    bus.req = '0;

    // Masking by en; en dropped mid-frame
    bus.req = '1;
    bus.en  = 6'b001000;
    frame(int'($urandom_range(1, 100)), 1'b0, 1'b1,
          1'b1, 1'b1);
    bus.req = '0;
    bus.en  = '1;

    // Timeout, then the next requester
    bus.req = 6'b000110;
    frame(0, 1'b1, 1'b1, 1'b0, 1'b1);
    frame(int'($urandom_range(1, 100)), 1'b0, 1'b1,
          1'b0, 1'b0);
    bus.req = '0;

    // Reset during SEND
    bus.req = 6'b001000;
    @(negedge clk);
    chk("t5_start", 32'(bus.drv_start), 32'd1);
    repeat (101) @(negedge clk);
    chk("t5_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("t5");
    rst  = 1'b0;
    last = N - 1;
    bus.req = 6'b010001;
    frame(int'($urandom_range(1, 100)), 1'b0, 1'b1,
          1'b0, 1'b0);
    bus.req = '0;

    // Randomized frames
    for (int n = 0; n < 8; n++) begin
      bus.req = N'($urandom);
      bus.en  = N'($urandom);
      for (int i = 0; i < N; i++)
        bus.colour[24*i +: 24] = 24'($urandom);
      if ((bus.req & bus.en) == '0) begin
        @(negedge clk);
        chk("rnd_idle", 32'(bus.busy), 32'd0);
      end else begin
        frame(int'($urandom_range(1, 300)), 1'b0, 1'b1,
              1'b0, 1'b1);
      end
      bus.req = '0;
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
